// File: rtl/synapse_drive.sv
// synapse_drive: weighted spike sum folded into a leaky, saturating 8-bit current trace.
// Latency: spike sampled at edge t -> current_out/current_valid after edge t+1 (two edges incl. sampling edge).
// Backpressure: cfg_ready drops during a weight clear sweep; spike path is never stalled.
// Optional feature macro: SYN_INHIB_EN (cfg_data[7] = inhibitory flag, cfg_data[6:0] = magnitude).
module synapse_drive #(
  parameter int N_IN        = 8,
  parameter int DECAY_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] spike_in,
  input  logic            spike_valid,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [3:0]      cfg_addr,
  input  logic [7:0]      cfg_data,
  input  logic            cfg_clear,
  output logic [7:0]      current_out,
  output logic            current_valid
);

  // Sum width: worst case N_IN * 255 fits without overflow.
  localparam int SW = 8 + $clog2(N_IN);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [4:0] N_IN_L   = 5'(N_IN);
  localparam logic [3:0] LAST_IDX = 4'(N_IN - 1);

  logic [0:0]    state;
  logic [3:0]    idx;
  logic [7:0]    w [N_IN];
  logic          wr_en;
  logic [7:0]    trace;
  logic [7:0]    trace_nxt;
  logic [7:0]    leak;
  logic [7:0]    kept;
  logic          s1_valid;

  // A clear request in the same cycle takes priority, so ready is withdrawn combinationally.
  assign cfg_ready = (state == ST_RUN) & ~cfg_clear;
  // Out-of-range addresses still complete the handshake but never touch a weight.
  assign wr_en     = cfg_valid & cfg_ready & ({1'b0, cfg_addr} < N_IN_L);

  // Clear sweep FSM: one weight zeroed per cycle, N_IN cycles, not restartable mid-sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      idx   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (cfg_clear) begin
            state <= ST_CLEAR;
            idx   <= '0;
          end
        end
        default: begin
          if (idx == LAST_IDX) state <= ST_RUN;
          idx <= idx + 4'd1;
        end
      endcase
    end
  end

  // Weight store: clear sweep and config writes are mutually exclusive (ready is low in CLEAR).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) w[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if ((state == ST_CLEAR) && (idx == 4'(i))) begin
          w[i] <= '0;
        end else if (wr_en && (cfg_addr == 4'(i))) begin
          w[i] <= cfg_data;
        end
      end
    end
  end

  // Leak term; trace - leak never underflows since leak <= trace.
  assign leak = trace >> DECAY_SHIFT;
  assign kept = trace - leak;

`ifdef SYN_INHIB_EN
  logic [SW-1:0]        exc_c, inh_c;
  logic [SW-1:0]        s1_exc, s1_inh;
  logic signed [SW+1:0] snxt;

  // Stage 1 combinational: split active weights into excitatory and inhibitory magnitudes.
  always_comb begin
    exc_c = '0;
    inh_c = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) begin
        if (w[i][7]) inh_c = inh_c + SW'(w[i][6:0]);
        else         exc_c = exc_c + SW'(w[i][6:0]);
      end
    end
  end

  // Stage 1 register: an unsampled cycle contributes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_exc   <= '0;
      s1_inh   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_exc   <= spike_valid ? exc_c : '0;
      s1_inh   <= spike_valid ? inh_c : '0;
      s1_valid <= spike_valid;
    end
  end

  // Signed intermediate two bits wider than the sums so neither end can wrap.
  assign snxt = $signed((SW+2)'(kept)) + $signed((SW+2)'(s1_exc)) - $signed((SW+2)'(s1_inh));

  // Clamp the next trace into 0..255.
  always_comb begin
    trace_nxt = snxt[7:0];
    if (snxt[SW+1])        trace_nxt = 8'd0;
    else if (|snxt[SW:8])  trace_nxt = 8'hFF;
  end
`else
  logic [SW-1:0] sum_c;
  logic [SW-1:0] s1_sum;
  logic [SW:0]   nxt;

  // Stage 1 combinational: sum of weights of the active inputs.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) sum_c = sum_c + SW'(w[i]);
    end
  end

  // Stage 1 register: an unsampled cycle contributes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sum   <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_sum   <= spike_valid ? sum_c : '0;
      s1_valid <= spike_valid;
    end
  end

  assign nxt = (SW+1)'(kept) + (SW+1)'(s1_sum);

  // Saturate the next trace at 255.
  always_comb begin
    trace_nxt = nxt[7:0];
    if (|nxt[SW:8]) trace_nxt = 8'hFF;
  end
`endif

  // Stage 2: trace leaks every cycle, even without a new sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace         <= '0;
      current_valid <= 1'b0;
    end else begin
      trace         <= trace_nxt;
      current_valid <= s1_valid;
    end
  end

  assign current_out = trace;

endmodule
